// File: rtl/fp_pkg.sv
// fp_pkg: shared FP datapath types, default widths and the shift-counter width helper
package fp_pkg;
  localparam int E_DEF = 8;
  localparam int M_DEF = 8;
  typedef enum logic [2:0] {IDLE, COMPARE, SHIFT, ADD, DONE} estado_alin_t;
  function automatic int cnt_w(input int m);
    return $clog2(m + 2);
  endfunction
endpackage

// File: rtl/alineador_mantisas_if.sv
// alineador_mantisas_if: operand/result handshake bundle between the aligner and its neighbours
interface alineador_mantisas_if #(parameter int E = 8, parameter int M = 8);
  logic         in_valid;
  logic         in_ready;
  logic [E-1:0] exp_a;
  logic [E-1:0] exp_b;
  logic [M-1:0] man_a;
  logic [M-1:0] man_b;
  logic         out_valid;
  logic         out_ready;
  logic [M:0]   mantisa_suma;
  logic [E-1:0] exponente_mayor;
  logic         cout_mantisa;
  modport master (output in_valid, exp_a, exp_b, man_a, man_b, out_ready,
                  input in_ready, out_valid, mantisa_suma, exponente_mayor, cout_mantisa);
  modport slave  (input in_valid, exp_a, exp_b, man_a, man_b, out_ready,
                  output in_ready, out_valid, mantisa_suma, exponente_mayor, cout_mantisa);
endinterface

// File: rtl/sumador_simple.sv
// sumador_simple: N-bit ripple-style adder with carry in and carry out
module sumador_simple #(parameter int N = 9) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

// File: rtl/alineador_mantisas.sv
// alineador_mantisas: picks the larger exponent, right-aligns the smaller mantissa serially, adds both
module alineador_mantisas
  import fp_pkg::*;
#(parameter int E = E_DEF, parameter int M = M_DEF) (
  input logic clk,
  input logic rst_n,
  alineador_mantisas_if.slave bus
);
  localparam int CW = cnt_w(M);
  localparam logic [E:0] DMAX = (E+1)'(M + 1);
  estado_alin_t state_q, state_d;
  logic [E-1:0] ea_q, ea_d, eb_q, eb_d, eg_q, eg_d, exp_q, exp_d;
  logic [M-1:0] ma_q, ma_d, mb_q, mb_d, mg_q, mg_d;
  logic [M:0]   sm_q, sm_d, suma_q, suma_d, sum;
  logic [CW-1:0] cnt_q, cnt_d, d;
  logic         cout_q, cout_d, ov_q, ov_d, co, a_big;
  logic [E-1:0] diff;
  assign a_big = ea_q >= eb_q;
  assign diff  = a_big ? ea_q - eb_q : eb_q - ea_q;
  // shifting by more than M+1 leaves nothing, so the count saturates there
  assign d     = ({1'b0, diff} > DMAX) ? CW'(M + 1) : diff[CW-1:0];
  sumador_simple #(.N(M + 1)) u_sum (
    .a({1'b1, mg_q}), .b(sm_q), .cin(1'b0), .s(sum), .cout(co)
  );
  always_comb begin
    state_d = state_q;
    ea_d = ea_q; eb_d = eb_q; ma_d = ma_q; mb_d = mb_q;
    eg_d = eg_q; mg_d = mg_q; sm_d = sm_q; cnt_d = cnt_q;
    suma_d = suma_q; exp_d = exp_q; cout_d = cout_q; ov_d = ov_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        ea_d = bus.exp_a; eb_d = bus.exp_b; ma_d = bus.man_a; mb_d = bus.man_b;
        state_d = COMPARE;
      end
      COMPARE: begin
        eg_d    = a_big ? ea_q : eb_q;
        mg_d    = a_big ? ma_q : mb_q;
        sm_d    = {1'b1, a_big ? mb_q : ma_q};
        cnt_d   = d;
        state_d = (d != '0) ? SHIFT : ADD;
      end
      SHIFT: begin
        sm_d    = sm_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? ADD : SHIFT;
      end
      ADD: begin
        suma_d = sum; cout_d = co; exp_d = eg_q; ov_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (ov_q && bus.out_ready) begin
        ov_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      eg_q <= '0; mg_q <= '0; sm_q <= '0; cnt_q <= '0;
      suma_q <= '0; exp_q <= '0; cout_q <= 1'b0; ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ea_q <= ea_d; eb_q <= eb_d; ma_q <= ma_d; mb_q <= mb_d;
      eg_q <= eg_d; mg_q <= mg_d; sm_q <= sm_d; cnt_q <= cnt_d;
      suma_q <= suma_d; exp_q <= exp_d; cout_q <= cout_d; ov_q <= ov_d;
    end
  assign bus.in_ready        = state_q == IDLE;
  assign bus.out_valid       = ov_q;
  assign bus.mantisa_suma    = suma_q;
  assign bus.exponente_mayor = exp_q;
  assign bus.cout_mantisa    = cout_q;
endmodule

// File: tb/tb_alineador_mantisas.sv
// tb_alineador_mantisas: directed corner cases plus random operands against an arithmetic reference
module tb_alineador_mantisas;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  alineador_mantisas_if #(.E(8), .M(8)) bus ();
  alineador_mantisas #(.E(8), .M(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic model(input int ea, eb, ma, mb, output int es, ec, ee, el);
    int big_m, small_m, dd, tot;
    ee      = ea >= eb ? ea : eb;
    big_m   = 256 + (ea >= eb ? ma : mb);
    small_m = 256 + (ea >= eb ? mb : ma);
    dd      = ea >= eb ? ea - eb : eb - ea;
    if (dd > 9) dd = 9;
    tot = big_m + (small_m / (1 << dd));
    es  = tot % 512;
    ec  = tot / 512;
    el  = 2 + dd;
  endtask
  task automatic run_op(input logic [7:0] ea, eb, ma, mb, input int hold);
    int es, ec, ee, el, lat;
    model(ea, eb, ma, mb, es, ec, ee, el);
    @(negedge clk);
    bus.exp_a = ea; bus.exp_b = eb; bus.man_a = ma; bus.man_b = mb;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk("latency", lat, el);
    chk("suma", 32'(bus.mantisa_suma), es);
    chk("cout", 32'(bus.cout_mantisa), ec);
    chk("exp", 32'(bus.exponente_mayor), ee);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.exp_a = 8'($urandom); bus.man_a = 8'($urandom);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_suma", 32'(bus.mantisa_suma), es);
      chk("hold_exp", 32'(bus.exponente_mayor), ee);
      chk("hold_ready", 32'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("drop_valid", 32'(bus.out_valid), 0);
    chk("idle_ready", 32'(bus.in_ready), 1);
  endtask
  initial begin
    logic [7:0] ea, eb;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exp_a = '0; bus.exp_b = '0; bus.man_a = '0; bus.man_b = '0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_suma", 32'(bus.mantisa_suma), 0);
    chk("rst_exp", 32'(bus.exponente_mayor), 0);
    chk("rst_cout", 32'(bus.cout_mantisa), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd5, 8'd5, 8'h80, 8'h80, 0);
    run_op(8'd10, 8'd7, 8'h00, 8'h00, 0);
    run_op(8'd7, 8'd10, 8'h00, 8'h00, 0);
    run_op(8'd200, 8'd3, 8'h55, 8'hFF, 0);
    run_op(8'd0, 8'd255, 8'hFF, 8'hFF, 0);
    run_op(8'd20, 8'd11, 8'h12, 8'h34, 0);
    run_op(8'd12, 8'd20, 8'hAB, 8'hCD, 4);
    // abort a long alignment mid-SHIFT, then confirm a clean restart
    @(negedge clk);
    bus.exp_a = 8'd200; bus.exp_b = 8'd3; bus.man_a = 8'h55; bus.man_b = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd10, 8'd7, 8'h00, 8'h00, 0);
    for (int i = 0; i < 40; i++) begin
      ea = 8'($urandom);
      eb = ($urandom % 2) ? 8'($urandom) : 8'(ea + 8'($urandom_range(0, 10)));
      run_op(ea, eb, 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
